// File: rtl/seq_gen_serial.sv
// Parallel-to-serial pattern transmitter: MSB-first words over valid/ready with a
// programmable idle gap, plus a "1011" line tracker producing a golden expect stream.
module seq_gen_serial #(
   parameter int unsigned DW  = 8,
   parameter int unsigned GAP = 0
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   output logic          o_ready,
   output logic          o_seq,
   output logic          o_busy,
   output logic          o_last,
   output logic          o_expect,
   output logic [7:0]    o_cnt
);

   localparam int unsigned    BW      = $clog2(DW);
   localparam logic [BW-1:0]  BIT_TOP = BW'(DW - 1);
   localparam logic [7:0]     GAP_TOP = 8'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
   typedef enum logic [1:0] {T0, T1, T10, T101} trk_e;

   state_e        state_q, state_d;
   trk_e          trk_q, trk_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]    gap_cnt_q, gap_cnt_d;
   logic          seq_q, seq_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          accept;

   assign o_ready  = (state_q == S_IDLE)
                  || ((state_q == S_SHIFT) && (bit_cnt_q == '0) && (GAP == 0))
                  || ((state_q == S_GAP) && (gap_cnt_q == '0));
   assign accept   = i_valid && o_ready;
   assign o_seq    = seq_q;
   assign o_busy   = (state_q != S_IDLE);
   assign o_last   = (state_q == S_SHIFT) && (bit_cnt_q == '0);
   assign o_expect = (trk_q == T101) && seq_q;
   assign o_cnt    = cnt_q;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      seq_d     = 1'b0;
      unique case (state_q)
         S_IDLE: ;
         S_SHIFT: begin
            if (bit_cnt_q != '0) begin
               seq_d     = shreg_q[DW-1];
               shreg_d   = shreg_q << 1;
               bit_cnt_d = bit_cnt_q - 1'b1;
            end else if (GAP == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d   = S_GAP;
               gap_cnt_d = GAP_TOP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
            else                 state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Accept is only possible on idle / last-bit / last-gap cycles, so it overrides.
      if (accept) begin
         state_d   = S_SHIFT;
         seq_d     = i_data[DW-1];
         shreg_d   = {i_data[DW-2:0], 1'b0};
         bit_cnt_d = BIT_TOP;
      end
   end

   always_comb begin
      trk_d = T0;
      unique case (trk_q)
         T0:      trk_d = seq_q ? T1   : T0;
         T1:      trk_d = seq_q ? T1   : T10;
         T10:     trk_d = seq_q ? T101 : T0;
         T101:    trk_d = seq_q ? T1   : T10;
         default: trk_d = T0;
      endcase
      cnt_d = cnt_q + {7'd0, o_expect};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= S_IDLE;
         trk_q     <= T0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         seq_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         trk_q     <= trk_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         seq_q     <= seq_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_gen_serial.sv
// Bench for seq_gen_serial: a GAP=0 and a GAP=2 instance checked every cycle against
// a queue-of-symbols line model with a sliding 4-bit "1011" window.
module tb_seq_gen_serial;

   typedef struct packed {
      logic b;
      logic busy;
      logic last;
   } sym_t;

   localparam int GAPS [2] = '{0, 2};

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] data [2];
   logic       vld  [2];
   logic [1:0] rdy_w, seq_w, busy_w, last_w, exp_w;
   logic [7:0] cnt_w [2];

   sym_t       mq   [2][$];
   sym_t       cur  [2];
   logic [3:0] hist [2];
   logic [7:0] mcnt [2];
   bit         acc  [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_gen_serial #(.DW(8), .GAP(0)) u_dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_data(data[0]), .i_valid(vld[0]),
      .o_ready(rdy_w[0]), .o_seq(seq_w[0]), .o_busy(busy_w[0]), .o_last(last_w[0]),
      .o_expect(exp_w[0]), .o_cnt(cnt_w[0])
   );

   seq_gen_serial #(.DW(8), .GAP(2)) u_dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_data(data[1]), .i_valid(vld[1]),
      .o_ready(rdy_w[1]), .o_seq(seq_w[1]), .o_busy(busy_w[1]), .o_last(last_w[1]),
      .o_expect(exp_w[1]), .o_cnt(cnt_w[1])
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         cur[i]  = '0;
         hist[i] = '0;
         mcnt[i] = '0;
         acc[i]  = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d_seq", i),    {7'd0, seq_w[i]},  {7'd0, cur[i].b});
         check($sformatf("d%0d_busy", i),   {7'd0, busy_w[i]}, {7'd0, cur[i].busy});
         check($sformatf("d%0d_last", i),   {7'd0, last_w[i]}, {7'd0, cur[i].last});
         check($sformatf("d%0d_expect", i), {7'd0, exp_w[i]},  {7'd0, hist[i] == 4'b1011});
         check($sformatf("d%0d_ready", i),  {7'd0, rdy_w[i]},  {7'd0, mq[i].size() == 0});
         check($sformatf("d%0d_cnt", i),    cnt_w[i],          mcnt[i]);
      end
   endtask

   // One clock: advance the line model at the edge, then compare 1 time unit later.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         acc[i] = 1'b0;
         if (rstn) begin
            acc[i] = vld[i] && (mq[i].size() == 0);
            if (acc[i]) begin
               for (int b = 7; b >= 0; b--)
                  mq[i].push_back('{b: data[i][b], busy: 1'b1, last: (b == 0)});
               for (int g = 0; g < GAPS[i]; g++)
                  mq[i].push_back('{b: 1'b0, busy: 1'b1, last: 1'b0});
            end
            if (hist[i] == 4'b1011) mcnt[i]++;
            cur[i]  = (mq[i].size() != 0) ? mq[i].pop_front() : sym_t'('0);
            hist[i] = {hist[i][2:0], cur[i].b};
         end
      end
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send(input int i, input logic [7:0] d);
      int n;
      n = 0;
      vld[i]  = 1'b1;
      data[i] = d;
      do begin
         tick();
         n++;
      end while (!acc[i] && n < 200);
      check($sformatf("d%0d_send_accepted", i), {7'd0, acc[i]}, 8'd1);
      vld[i] = 1'b0;
   endtask

   // Assert reset between clock edges and check the outputs clear without an edge.
   task automatic async_reset();
      #2;
      rstn   = 1'b0;
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      tick();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn    = 1'b0;
      vld[0]  = 1'b0;
      vld[1]  = 1'b0;
      data[0] = '0;
      data[1] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      idle(20);
      async_reset();

      send(0, 8'hB6);
      idle(10);
      check("b6_cnt", cnt_w[0], 8'd2);

      send(0, 8'h0B);
      send(0, 8'hB0);
      idle(10);
      check("boundary_cnt", cnt_w[0], 8'd4);

      send(0, 8'h01);
      send(0, 8'h60);
      idle(10);
      check("gap0_0160_cnt", cnt_w[0], 8'd5);

      send(1, 8'h01);
      send(1, 8'h60);
      idle(12);
      check("gap2_0160_cnt", cnt_w[1], 8'd0);

      send(0, 8'hFF);
      idle(3);
      async_reset();
      check("midword_reset_cnt", cnt_w[0], 8'd0);
      send(0, 8'hB0);
      idle(10);
      check("after_reset_b0_cnt", cnt_w[0], 8'd1);

      for (int w = 0; w < 256; w++) send(0, 8'hBB);
      idle(10);
      check("wrap_cnt", cnt_w[0], 8'd1);

      for (int t = 0; t < 600; t++) begin
         if (t == 300) async_reset();
         for (int i = 0; i < 2; i++) begin
            vld[i]  = ($urandom_range(0, 3) != 0);
            data[i] = 8'($urandom);
         end
         tick();
      end
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      idle(15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
